// File: rtl/h2_seq_pkg.sv
// Shared types for the H2 command sequencer.
// Opcodes, the queued command bundle, FSM states and helpers.
package h2_seq_pkg;

    typedef enum logic [2:0] {
        OP_LOAD_SPM = 3'd0,
        OP_LOAD_KSK = 3'd1,
        OP_LOAD_ENC = 3'd2,
        OP_STORE    = 3'd3,
        OP_VP_RUN   = 3'd4
    } seq_op_e;

    // op stays a raw 3-bit field so illegal codes survive the queue
    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] ptr;
        logic [31:0] size;
        logic [31:0] aux;
    } seq_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    function automatic logic [31:0] rd_command(input logic [2:0] op);
        return {29'd0, op};
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_VP_RUN;
    endfunction

    function automatic logic op_is_load(input logic [2:0] op);
        return op == OP_LOAD_SPM || op == OP_LOAD_KSK || op == OP_LOAD_ENC;
    endfunction

endpackage

// File: rtl/h2_cmd_fifo.sv
// Command queue for the H2 sequencer.
// Synchronous FIFO with flush and a registered pop output.
module h2_cmd_fifo
    import h2_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  seq_cmd_t                 wdata,
    input  logic                     pop,
    output seq_cmd_t                 rdata,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    seq_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push & ~full & ~flush;
    assign rd_en = pop & ~empty;

    // Storage array; no reset needed on the data itself
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and the registered head; flush beats push, not pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (rd_en) begin
                rdata <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_en, rd_en})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/h2_cmd_sequencer.sv
// Host command sequencer for the H2 accelerator.
// Issues queued DDR load/store and VP commands one at a time.
module h2_cmd_sequencer
    import h2_seq_pkg::*;
#(
    parameter int CMD_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [63:0]                 cmd_addr,
    input  logic [63:0]                 cmd_ptr,
    input  logic [31:0]                 cmd_size,
    input  logic [31:0]                 cmd_aux,
    input  logic                        flush,
    input  logic                        clear_err,
    output logic                        axi_rd_start,
    output logic                        axi_wr_start,
    output logic [31:0]                 axi_rd_command,
    output logic [63:0]                 base_addr,
    output logic [63:0]                 data_ptr,
    output logic [31:0]                 data_size_bytes,
    output logic [31:0]                 encode_base_addr,
    output logic                        o_vp_start,
    output logic [31:0]                 o_vp_pc,
    input  logic                        axi_rd_done,
    input  logic                        axi_wr_done,
    input  logic                        i_vp_done,
    output logic                        busy,
    output logic [$clog2(CMD_DEPTH):0]  cmd_count,
    output logic [15:0]                 done_count,
    output logic                        err_timeout,
    output logic                        err_illegal,
    output logic [2:0]                  err_op
);

    localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

    seq_state_e  state;
    seq_cmd_t    wdata;
    seq_cmd_t    head;
    logic        push;
    logic        pop;
    logic        pending;
    logic        first_run;
    logic [2:0]  cur_op;
    logic [31:0] wd_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        done_sel;
    logic        done_hit;
    logic        timeout_hit;

    assign cmd_ready = ~fifo_full & ~err_timeout;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == ST_IDLE) & ~fifo_empty & ~pending;

    assign wdata.op   = cmd_op;
    assign wdata.addr = cmd_addr;
    assign wdata.ptr  = cmd_ptr;
    assign wdata.size = cmd_size;
    assign wdata.aux  = cmd_aux;

    h2_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .flush (flush | timeout_hit),
        .count (cmd_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Select the done input belonging to the engine that was started
    always_comb begin
        done_sel = 1'b0;
        if (op_is_load(cur_op)) begin
            done_sel = axi_rd_done;
        end else if (cur_op == OP_STORE) begin
            done_sel = axi_wr_done;
        end else if (cur_op == OP_VP_RUN) begin
            done_sel = i_vp_done;
        end
    end

    // A done in the first RUN cycle is stale; a real done beats the watchdog
    assign done_hit    = (state == ST_RUN) & ~first_run & done_sel;
    assign timeout_hit = (TO != '0) & (state == ST_RUN) & ~done_hit
                       & (wd_cnt + 32'd1 == TO);

    // Issue FSM with watchdog, completion counter and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            pending          <= 1'b0;
            first_run        <= 1'b0;
            cur_op           <= '0;
            wd_cnt           <= '0;
            axi_rd_start     <= 1'b0;
            axi_wr_start     <= 1'b0;
            axi_rd_command   <= '0;
            base_addr        <= '0;
            data_ptr         <= '0;
            data_size_bytes  <= '0;
            encode_base_addr <= '0;
            o_vp_start       <= 1'b0;
            o_vp_pc          <= '0;
            busy             <= 1'b0;
            done_count       <= '0;
            err_timeout      <= 1'b0;
            err_illegal      <= 1'b0;
            err_op           <= '0;
        end else begin
            o_vp_start <= 1'b0;
            pending    <= pop;
            busy       <= (state != ST_IDLE) | ~fifo_empty | pending;
            if (clear_err) begin
                err_timeout <= 1'b0;
                err_illegal <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        if (op_legal(head.op)) begin
                            cur_op          <= head.op;
                            base_addr       <= head.addr;
                            data_ptr        <= head.ptr;
                            data_size_bytes <= head.size;
                            first_run       <= 1'b1;
                            wd_cnt          <= '0;
                            state           <= ST_RUN;
                            if (op_is_load(head.op)) begin
                                axi_rd_start   <= 1'b1;
                                axi_rd_command <= rd_command(head.op);
                                if (head.op == OP_LOAD_ENC) begin
                                    encode_base_addr <= head.aux;
                                end
                            end else if (head.op == OP_STORE) begin
                                axi_wr_start <= 1'b1;
                            end else begin
                                o_vp_start <= 1'b1;
                                o_vp_pc    <= head.aux;
                            end
                        end else begin
                            err_illegal <= 1'b1;
                            err_op      <= head.op;
                        end
                    end
                end
                ST_RUN: begin
                    first_run <= 1'b0;
                    if (TO != '0) begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                    if (done_hit) begin
                        axi_rd_start <= 1'b0;
                        axi_wr_start <= 1'b0;
                        done_count   <= done_count + 16'd1;
                        state        <= ST_GAP;
                    end else if (timeout_hit) begin
                        axi_rd_start <= 1'b0;
                        axi_wr_start <= 1'b0;
                        err_timeout  <= 1'b1;
                        err_op       <= cur_op;
                        state        <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h2_cmd_sequencer.sv
// Directed bench for h2_cmd_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_h2_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [63:0] cmd_addr = '0;
    logic [63:0] cmd_ptr = '0;
    logic [31:0] cmd_size = '0;
    logic [31:0] cmd_aux = '0;
    logic        flush = 1'b0;
    logic        clear_err = 1'b0;
    logic        axi_rd_start;
    logic        axi_wr_start;
    logic [31:0] axi_rd_command;
    logic [63:0] base_addr;
    logic [63:0] data_ptr;
    logic [31:0] data_size_bytes;
    logic [31:0] encode_base_addr;
    logic        o_vp_start;
    logic [31:0] o_vp_pc;
    logic        axi_rd_done = 1'b0;
    logic        axi_wr_done = 1'b0;
    logic        i_vp_done = 1'b0;
    logic        busy;
    logic [3:0]  cmd_count;
    logic [15:0] done_count;
    logic        err_timeout;
    logic        err_illegal;
    logic [2:0]  err_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    h2_cmd_sequencer #(
        .CMD_DEPTH      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_ptr          (cmd_ptr),
        .cmd_size         (cmd_size),
        .cmd_aux          (cmd_aux),
        .flush            (flush),
        .clear_err        (clear_err),
        .axi_rd_start     (axi_rd_start),
        .axi_wr_start     (axi_wr_start),
        .axi_rd_command   (axi_rd_command),
        .base_addr        (base_addr),
        .data_ptr         (data_ptr),
        .data_size_bytes  (data_size_bytes),
        .encode_base_addr (encode_base_addr),
        .o_vp_start       (o_vp_start),
        .o_vp_pc          (o_vp_pc),
        .axi_rd_done      (axi_rd_done),
        .axi_wr_done      (axi_wr_done),
        .i_vp_done        (i_vp_done),
        .busy             (busy),
        .cmd_count        (cmd_count),
        .done_count       (done_count),
        .err_timeout      (err_timeout),
        .err_illegal      (err_illegal),
        .err_op           (err_op)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] p, input logic [31:0] s,
                        input logic [31:0] x);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_ptr   = p;
        cmd_size  = s;
        cmd_aux   = x;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", cmd_count, 0);
        chk("rst_rd_start", axi_rd_start, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_base", base_addr, 0);

        // single LOAD_SPM: issue latency 2, done after 10 RUN cycles
        push(3'd0, 64'h1000, 64'h40, 32'd4096, 32'd0);
        chk("t1_count_push", cmd_count, 1);
        tick();
        chk("t1_start_t1", axi_rd_start, 0);
        chk("t1_count_pop", cmd_count, 0);
        tick();
        chk("t1_start_t2", axi_rd_start, 1);
        chk("t1_rd_cmd", axi_rd_command, 0);
        chk("t1_addr", base_addr, 64'h1000);
        chk("t1_ptr", data_ptr, 64'h40);
        chk("t1_size", data_size_bytes, 4096);
        chk("t1_busy", busy, 1);
        repeat (9) tick();
        chk("t1_start_hold", axi_rd_start, 1);
        axi_rd_done = 1'b1;
        tick();
        axi_rd_done = 1'b0;
        chk("t1_start_drop", axi_rd_start, 0);
        chk("t1_done_count", done_count, 1);
        tick();
        tick();
        chk("t1_busy_fall", busy, 0);

        // LOAD_ENC, VP_RUN, STORE back-to-back
        push(3'd2, 64'h2000, 64'h80, 32'd256, 32'h200);
        push(3'd4, 64'h0, 64'h0, 32'd0, 32'h80);
        push(3'd3, 64'h3000, 64'h100, 32'd512, 32'd0);
        chk("t2_enc_start", axi_rd_start, 1);
        chk("t2_enc_cmd", axi_rd_command, 2);
        chk("t2_enc_base", encode_base_addr, 32'h200);
        chk("t2_count", cmd_count, 2);
        repeat (3) tick();
        axi_rd_done = 1'b1;
        tick();
        axi_rd_done = 1'b0;
        chk("t2_enc_drop", axi_rd_start, 0);
        chk("t2_dc_enc", done_count, 2);
        tick();
        chk("t2_gap1_vp", o_vp_start, 0);
        tick();
        chk("t2_gap2_vp", o_vp_start, 0);
        tick();
        chk("t2_vp_start", o_vp_start, 1);
        chk("t2_vp_pc", o_vp_pc, 32'h80);
        chk("t2_vp_rd_low", axi_rd_start, 0);
        chk("t2_vp_wr_low", axi_wr_start, 0);
        i_vp_done = 1'b1;
        tick();
        i_vp_done = 1'b0;
        chk("t2_vp_pulse", o_vp_start, 0);
        chk("t2_stale_done", done_count, 2);
        axi_rd_done = 1'b1;
        axi_wr_done = 1'b1;
        tick();
        axi_rd_done = 1'b0;
        axi_wr_done = 1'b0;
        chk("t2_other_done", done_count, 2);
        i_vp_done = 1'b1;
        tick();
        i_vp_done = 1'b0;
        chk("t2_dc_vp", done_count, 3);
        tick();
        tick();
        chk("t2_st_gap", axi_wr_start, 0);
        tick();
        chk("t2_st_start", axi_wr_start, 1);
        chk("t2_st_addr", base_addr, 64'h3000);
        chk("t2_pc_hold", o_vp_pc, 32'h80);
        chk("t2_enc_hold", encode_base_addr, 32'h200);
        tick();
        axi_wr_done = 1'b1;
        tick();
        axi_wr_done = 1'b0;
        chk("t2_st_drop", axi_wr_start, 0);
        chk("t2_dc_st", done_count, 4);
        tick();
        tick();
        chk("t2_busy_fall", busy, 0);

        // fill while stalled, then watchdog fires at RUN cycle 16
        push(3'd3, 64'h5000, 64'h0, 32'd64, 32'd0);
        for (int i = 0; i < 8; i++) begin
            push(3'd0, 64'(i), 64'h0, 32'd8, 32'd0);
        end
        chk("t3_count_full", cmd_count, 8);
        chk("t3_ready_full", cmd_ready, 0);
        chk("t3_wr_start", axi_wr_start, 1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t3_ninth_held", cmd_count, 8);
        repeat (8) tick();
        chk("t4_no_to_yet", err_timeout, 0);
        chk("t4_start_yet", axi_wr_start, 1);
        tick();
        chk("t4_err_to", err_timeout, 1);
        chk("t4_err_op", err_op, 3);
        chk("t4_start_drop", axi_wr_start, 0);
        chk("t4_fifo_empty", cmd_count, 0);
        chk("t4_ready_low", cmd_ready, 0);
        chk("t4_dc_same", done_count, 4);
        tick();
        tick();
        chk("t4_ready_hold", cmd_ready, 0);
        chk("t4_busy_fall", busy, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t4_to_clear", err_timeout, 0);
        chk("t4_ready_back", cmd_ready, 1);

        // illegal opcode dropped, following LOAD_KSK still issues
        push(3'd6, 64'h6000, 64'h0, 32'd0, 32'd0);
        push(3'd1, 64'h7000, 64'h10, 32'd32, 32'd0);
        chk("t5_ill_early", err_illegal, 0);
        tick();
        chk("t5_err_ill", err_illegal, 1);
        chk("t5_err_op", err_op, 6);
        chk("t5_no_start", axi_rd_start, 0);
        tick();
        chk("t5_ksk_wait", axi_rd_start, 0);
        tick();
        chk("t5_ksk_start", axi_rd_start, 1);
        chk("t5_ksk_cmd", axi_rd_command, 1);
        chk("t5_ksk_addr", base_addr, 64'h7000);
        tick();
        axi_rd_done = 1'b1;
        tick();
        axi_rd_done = 1'b0;
        chk("t5_dc", done_count, 5);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t5_ill_clear", err_illegal, 0);

        // flush mid-RUN, then reset mid-RUN, then a fresh command
        push(3'd0, 64'h8000, 64'h0, 32'd16, 32'd0);
        tick();
        tick();
        chk("t6_start", axi_rd_start, 1);
        push(3'd1, 64'h1, 64'h0, 32'd1, 32'd0);
        push(3'd2, 64'h2, 64'h0, 32'd1, 32'd0);
        chk("t6_count2", cmd_count, 2);
        flush = 1'b1;
        cmd_valid = 1'b1;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("t6_flush_cnt", cmd_count, 0);
        chk("t6_flush_run", axi_rd_start, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_start", axi_rd_start, 0);
        chk("t6_rst_dc", done_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", cmd_ready, 1);
        chk("t6_rst_addr", base_addr, 0);
        chk("t6_rst_cmd", axi_rd_command, 0);
        push(3'd0, 64'h9000, 64'h20, 32'd128, 32'd0);
        tick();
        tick();
        chk("t6_new_start", axi_rd_start, 1);
        chk("t6_new_addr", base_addr, 64'h9000);
        tick();
        axi_rd_done = 1'b1;
        tick();
        axi_rd_done = 1'b0;
        chk("t6_new_dc", done_count, 1);
        tick();
        tick();
        chk("t6_busy_fall", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
